// File: rtl/ft245_report_tx.sv
// FT245-style FIFO report transmitter: a valid host request byte is answered
// with an NBYTES report packet followed by one send-immediate pulse.
module ft245_report_tx #(
    parameter int         NBYTES   = 16,
    parameter logic [7:0] CMD_REQ  = 8'h01,
    parameter int         TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NBYTES*8-1:0] rec,
    input  logic                rxf,
    input  logic                txe,
    output logic                rd,
    output logic                wr,
    inout  wire  [7:0]          d,
    output logic                SI,
    output logic                busy,
    output logic                pkt_done,
    output logic                bad_cmd
);
    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]       LAST_IDX = 5'(NBYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD, S_RD_REL, S_SNAP, S_WR_SET, S_WR_STB, S_WR_HOLD, S_SI_LO, S_SI_HI
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       idx_reg, idx_next;
    logic             req_reg, req_next;
    logic [7:0]       dout_reg, dout_next;
    logic [7:0]       shadow_reg [NBYTES];
    logic             snap_load;
    logic             tick, tick_next;
    logic [7:0]       shadow_sel;

    logic rd_reg, wr_reg, si_reg, busy_reg, pkt_done_reg, bad_cmd_reg, d_oe_reg;
    logic bad_cmd_next;

    wire [7:0] rec_byte [NBYTES];

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_rec_split
            assign rec_byte[gi] = rec[8*gi +: 8];
        end
    endgenerate

    assign tick      = (cnt_reg == CNT_MAX);
    assign cnt_next  = tick ? '0 : cnt_reg + CNT_W'(1);
    assign tick_next = (cnt_next == CNT_MAX);

    always_comb begin
        shadow_sel = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_reg == 5'(i)) begin
                shadow_sel = shadow_reg[i];
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        req_next     = req_reg;
        dout_next    = dout_reg;
        bad_cmd_next = 1'b0;
        snap_load    = 1'b0;
        if (tick) begin
            case (state_reg)
                S_IDLE:    if (!rxf) state_next = S_RD;
                S_RD: begin
                    req_next     = (d == CMD_REQ);
                    bad_cmd_next = (d != CMD_REQ);
                    state_next   = S_RD_REL;
                end
                S_RD_REL:  state_next = req_reg ? S_SNAP : S_IDLE;
                S_SNAP: begin
                    snap_load  = 1'b1;
                    idx_next   = 5'd0;
                    state_next = S_WR_SET;
                end
                S_WR_SET: begin
                    if (!txe) begin
                        dout_next  = shadow_sel;
                        state_next = S_WR_STB;
                    end
                end
                S_WR_STB:  state_next = S_WR_HOLD;
                S_WR_HOLD: begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_SI_LO;
                    end else begin
                        idx_next   = idx_reg + 5'd1;
                        state_next = S_WR_SET;
                    end
                end
                S_SI_LO:   state_next = S_SI_HI;
                S_SI_HI:   state_next = S_IDLE;
                default:   state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state, so each one is a clean
    // Moore output; pkt_done lands on the final clk of SI_HI.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= 5'd0;
            req_reg      <= 1'b0;
            dout_reg     <= 8'h00;
            rd_reg       <= 1'b1;
            wr_reg       <= 1'b0;
            si_reg       <= 1'b1;
            busy_reg     <= 1'b0;
            pkt_done_reg <= 1'b0;
            bad_cmd_reg  <= 1'b0;
            d_oe_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            req_reg      <= req_next;
            dout_reg     <= dout_next;
            rd_reg       <= (state_next != S_RD);
            wr_reg       <= (state_next == S_WR_STB);
            si_reg       <= (state_next != S_SI_LO);
            busy_reg     <= (state_next != S_IDLE);
            pkt_done_reg <= (state_next == S_SI_HI) && tick_next;
            bad_cmd_reg  <= bad_cmd_next;
            d_oe_reg     <= (state_next == S_WR_STB) || (state_next == S_WR_HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (snap_load) begin
            for (int i = 0; i < NBYTES; i++) begin
                shadow_reg[i] <= rec_byte[i];
            end
        end
    end

    assign d        = d_oe_reg ? dout_reg : 8'hzz;
    assign rd       = rd_reg;
    assign wr       = wr_reg;
    assign SI       = si_reg;
    assign busy     = busy_reg;
    assign pkt_done = pkt_done_reg;
    assign bad_cmd  = bad_cmd_reg;

endmodule
